// File: rtl/vga_sync_rx_if.sv
// vga_sync_rx_if: sync inputs and recovered timing outputs of vga_sync_rx.
// Macro VGA_SYNC_RX_ERRCNT_EN adds the err_count signal.
interface vga_sync_rx_if;
   logic        tick;
   logic        h_sync;
   logic        v_sync;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        video_on;
   logic        locked;
   logic        frame_start;
   logic        sync_err;
`ifdef VGA_SYNC_RX_ERRCNT_EN
   logic [15:0] err_count;

   modport master (
      output tick, h_sync, v_sync,
      input  pixel_x, pixel_y, video_on, locked,
      input  frame_start, sync_err, err_count
   );

   modport slave (
      input  tick, h_sync, v_sync,
      output pixel_x, pixel_y, video_on, locked,
      output frame_start, sync_err, err_count
   );
`else
   modport master (
      output tick, h_sync, v_sync,
      input  pixel_x, pixel_y, video_on, locked,
      input  frame_start, sync_err
   );

   modport slave (
      input  tick, h_sync, v_sync,
      output pixel_x, pixel_y, video_on, locked,
      output frame_start, sync_err
   );
`endif
endinterface

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: locks a local h/v counter pair onto incoming h/v sync.
// Macro VGA_SYNC_RX_ERRCNT_EN adds a saturating sync error counter.
module vga_sync_rx #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int LOCK_LINES = 4,
   parameter int MISS_MAX   = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   vga_sync_rx_if.slave bus
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_SS_C = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_SS_C = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
   localparam logic [3:0] LOCK_C = 4'(LOCK_LINES);
   localparam logic [3:0] MISS_C = 4'(MISS_MAX);

   typedef enum logic [1:0] {
      SEARCH    = 2'd0,
      H_ALIGNED = 2'd1,
      LOCKED    = 2'd2
   } state_t;

   state_t     state_q, state_n;
   logic [9:0] h_cnt, v_cnt;
   logic [9:0] h_cnt_n, v_cnt_n;
   logic [3:0] match_q, match_n;
   logic [3:0] miss_q, miss_n;
   logic       hs_d, vs_d;
   logic       sync_err_q, sync_err_n;
   logic       frame_q, frame_n;

   logic       h_wrap;
   logic [9:0] h_free, v_free;
   logic       h_edge, v_edge;
   logic       h_exp, v_exp;
   logic       h_err, v_err;

   assign h_wrap = (h_cnt == H_LAST);
   assign h_free = h_wrap ? 10'd0 : h_cnt + 10'd1;
   assign v_free = !h_wrap ? v_cnt :
                   (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;

   assign h_edge = bus.tick & bus.h_sync & ~hs_d;
   assign v_edge = bus.tick & bus.v_sync & ~vs_d;
   assign h_exp  = bus.tick & (h_free == H_SS_C);
   assign v_exp  = bus.tick & h_wrap & (v_free == V_SS_C);
   assign h_err  = h_edge ^ h_exp;
   assign v_err  = v_edge ^ v_exp;

   // next-state, counter reload and pulse decisions for one tick
   always_comb begin
      state_n    = state_q;
      match_n    = match_q;
      miss_n     = miss_q;
      h_cnt_n    = bus.tick ? h_free : h_cnt;
      v_cnt_n    = bus.tick ? v_free : v_cnt;
      sync_err_n = 1'b0;
      frame_n    = 1'b0;
      unique case (state_q)
         SEARCH: begin
            if (h_edge) begin
               h_cnt_n = H_SS_C;
               match_n = h_exp ? match_q + 4'd1 : 4'd1;
               if (match_n == LOCK_C)
                  state_n = H_ALIGNED;
            end
         end
         H_ALIGNED: begin
            if (h_err) begin
               state_n    = SEARCH;
               match_n    = 4'd0;
               sync_err_n = 1'b1;
            end else if (v_edge) begin
               v_cnt_n = V_SS_C;
               miss_n  = 4'd0;
               state_n = LOCKED;
            end
         end
         LOCKED: begin
            frame_n = bus.tick & h_wrap & (v_cnt == V_LAST);
            if (h_err | v_err) begin
               sync_err_n = 1'b1;
               miss_n     = miss_q + 4'd1;
               if (miss_q + 4'd1 == MISS_C) begin
                  state_n = SEARCH;
                  match_n = 4'd0;
                  miss_n  = 4'd0;
               end
            end else if (h_edge) begin
               miss_n = 4'd0;
            end
         end
         default: begin
            state_n = SEARCH;
            match_n = 4'd0;
            miss_n  = 4'd0;
         end
      endcase
   end

   // state, counters, edge history and pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SEARCH;
         h_cnt      <= '0;
         v_cnt      <= '0;
         match_q    <= '0;
         miss_q     <= '0;
         hs_d       <= 1'b0;
         vs_d       <= 1'b0;
         sync_err_q <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         state_q    <= state_n;
         h_cnt      <= h_cnt_n;
         v_cnt      <= v_cnt_n;
         match_q    <= match_n;
         miss_q     <= miss_n;
         sync_err_q <= sync_err_n;
         frame_q    <= frame_n;
         if (bus.tick) begin
            hs_d <= bus.h_sync;
            vs_d <= bus.v_sync;
         end
      end
   end

   assign bus.pixel_x     = h_cnt;
   assign bus.pixel_y     = v_cnt;
   assign bus.locked      = (state_q == LOCKED);
   assign bus.video_on    = (state_q == LOCKED) &
                            (h_cnt < H_VIS) & (v_cnt < V_VIS);
   assign bus.frame_start = frame_q;
   assign bus.sync_err    = sync_err_q;

`ifdef VGA_SYNC_RX_ERRCNT_EN
   logic [15:0] err_cnt_q;

   // saturating tally of sync errors since reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt_q <= '0;
      else if (sync_err_n && err_cnt_q != 16'hFFFF)
         err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign bus.err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives a reduced-size timing generator into vga_sync_rx
// and scores recovered timing against the transmitter delayed one tick.
module tb_vga_sync_rx;
   localparam int HD = 16, HF = 4, HS = 4, HB = 4;
   localparam int VD = 10, VF = 3, VS = 2, VB = 3;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int HSS = HD + HF;
   localparam int VSS = VD + VF;
   localparam int FRAME = HT * VT;

   typedef struct {
      int x;
      int y;
      bit vid;
      bit lk;
      bit fs;
      bit se;
   } exp_t;

   logic clk;
   logic rst_n;
   vga_sync_rx_if bus();

   vga_sync_rx #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .LOCK_LINES(4), .MISS_MAX(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   exp_t q[$];
   int   tx_x, tx_y;
   bit   track, nx_lk, nx_serr;
   bit   h_force_hi, h_force_lo;
   int   errs, checks;
   int   se_cnt, fs_cnt;
   logic mon_t;
   exp_t me;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d want %0d (tx %0d,%0d)",
                  nm, act, exp, tx_x, tx_y);
      end
   endtask

   task automatic one_clk(input bit t);
      exp_t e;
      @(negedge clk);
      bus.tick   = t;
      bus.h_sync = h_force_hi |
                   (!h_force_lo && tx_x >= HSS && tx_x < HSS + HS);
      bus.v_sync = (tx_y >= VSS && tx_y < VSS + VS);
      @(posedge clk);
      if (t) begin
         if (track) begin
            e.x   = tx_x;
            e.y   = tx_y;
            e.lk  = nx_lk;
            e.vid = nx_lk && tx_x < HD && tx_y < VD;
            e.fs  = nx_lk && tx_x == 0 && tx_y == 0;
            e.se  = nx_serr;
            q.push_back(e);
         end
         if (tx_x == HT - 1) begin
            tx_x = 0;
            tx_y = (tx_y == VT - 1) ? 0 : tx_y + 1;
         end else begin
            tx_x++;
         end
      end
   endtask

   task automatic run_ticks(input int n);
      repeat (n) begin
         one_clk(1'b1);
         one_clk(1'b0);
         one_clk(1'b0);
         one_clk(1'b0);
      end
   endtask

   task automatic adv_to(input int x, input int y);
      int n = 0;
      while (!(tx_x == x && tx_y == y) && n < 2 * FRAME) begin
         run_ticks(1);
         n++;
      end
      if (n >= 2 * FRAME) check("adv_to_timeout", n, 0);
   endtask

   task automatic wait_lock(input string nm);
      track = 1'b0;
      adv_to(0, VSS);
      #1 check({nm, "_pre"}, int'(bus.locked), 0);
      track = 1'b1;
      run_ticks(1);
      #1 check(nm, int'(bus.locked), 1);
   endtask

   // scoreboard monitor: pops one expectation per tick, pulses idle otherwise
   always begin
      @(posedge clk);
      mon_t = bus.tick;
      @(negedge clk);
      if (bus.sync_err) se_cnt++;
      if (bus.frame_start) fs_cnt++;
      if (mon_t && q.size() > 0) begin
         me = q.pop_front();
         check("sb_x", int'(bus.pixel_x), me.x);
         check("sb_y", int'(bus.pixel_y), me.y);
         check("sb_video", int'(bus.video_on), int'(me.vid));
         check("sb_locked", int'(bus.locked), int'(me.lk));
         check("sb_frame", int'(bus.frame_start), int'(me.fs));
         check("sb_err", int'(bus.sync_err), int'(me.se));
      end else if (!mon_t && track) begin
         check("idle_frame", int'(bus.frame_start), 0);
         check("idle_err", int'(bus.sync_err), 0);
      end
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fs0, se0, nerr, px, py;
      rst_n      = 1'b0;
      bus.tick   = 1'b0;
      bus.h_sync = 1'b0;
      bus.v_sync = 1'b0;
      tx_x = 0; tx_y = 0;
      track = 1'b0; nx_lk = 1'b1; nx_serr = 1'b0;
      h_force_hi = 1'b0; h_force_lo = 1'b0;
      errs = 0; checks = 0; se_cnt = 0; fs_cnt = 0;

      #17;
      check("rst_x", int'(bus.pixel_x), 0);
      check("rst_y", int'(bus.pixel_y), 0);
      check("rst_video", int'(bus.video_on), 0);
      check("rst_locked", int'(bus.locked), 0);
      check("rst_frame", int'(bus.frame_start), 0);
      check("rst_err", int'(bus.sync_err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      wait_lock("lock0");
      check("acq_no_err", se_cnt, 0);

      fs0 = fs_cnt;
      run_ticks(2 * FRAME);
      #1 check("fs_per_frame", fs_cnt - fs0, 2);
      check("track_no_err", se_cnt, 0);

      adv_to(5, 2);
      se0 = se_cnt;
      repeat (3) begin
         h_force_hi = 1'b1;
         nx_serr    = 1'b1;
         run_ticks(1);
         h_force_hi = 1'b0;
         nx_serr    = 1'b0;
         run_ticks(HT - 1);
      end
      #1 check("glitch_errs", se_cnt - se0, 3);
      check("glitch_locked", int'(bus.locked), 1);

      adv_to(0, 2);
      se0 = se_cnt;
      nerr = 0;
      h_force_lo = 1'b1;
      for (int i = 0; i < 3 * HT; i++) begin
         nx_serr = track && tx_x == HSS;
         if (nx_serr) begin
            nerr++;
            if (nerr == 3) nx_lk = 1'b0;
         end
         run_ticks(1);
         if (!nx_lk) begin
            #1 check("drop_locked", int'(bus.locked), 0);
            check("drop_video", int'(bus.video_on), 0);
            track = 1'b0;
            nx_lk = 1'b1;
         end
         nx_serr = 1'b0;
      end
      h_force_lo = 1'b0;
      run_ticks(1);
      #1 check("drop_video_vis", int'(bus.video_on), 0);
      check("drop_errs", se_cnt - se0, 3);
      wait_lock("relock_h");

      run_ticks(HT + 3);
      #1 px = int'(bus.pixel_x);
      py = int'(bus.pixel_y);
      repeat (50) one_clk(1'b0);
      #1 check("hold_x", int'(bus.pixel_x), px);
      check("hold_y", int'(bus.pixel_y), py);
      se0 = se_cnt;
      run_ticks(FRAME);
      #1 check("hold_resume_err", se_cnt - se0, 0);

`ifdef VGA_SYNC_RX_ERRCNT_EN
      check("err_count", int'(bus.err_count), se_cnt);
`endif

      adv_to(10, 6);
      track = 1'b0;
      bus.tick = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_x", int'(bus.pixel_x), 0);
      check("mid_rst_y", int'(bus.pixel_y), 0);
      check("mid_rst_video", int'(bus.video_on), 0);
      check("mid_rst_locked", int'(bus.locked), 0);
      check("mid_rst_frame", int'(bus.frame_start), 0);
      check("mid_rst_err", int'(bus.sync_err), 0);
`ifdef VGA_SYNC_RX_ERRCNT_EN
      check("mid_rst_errcnt", int'(bus.err_count), 0);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_lock("relock_rst");
      run_ticks(FRAME / 2);

      repeat (4) @(negedge clk);
      check("sb_drain", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
